// File: rtl/corefifo_pkg.sv
// Shared COREFIFO definitions: default geometry, pointer width and Gray helpers.
// Both pointer-domain blocks import this so they agree on pointer width.
package corefifo_pkg;

    localparam int CF_ADDRWIDTH    = 3;
    localparam int CF_AFULL_THRESH = 6;
    localparam int PTRW            = CF_ADDRWIDTH + 1;

    typedef logic [PTRW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTRW-1] = g[PTRW-1];
        for (int i = PTRW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary converter (prefix XOR from the MSB down).
// Shared by the write-side and read-side pointer generators.
module corefifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin      = '0;
        bin[W-1] = gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/corefifo_wr_ptr_gray_gen.sv
// Write-side pointer/flag generator for the async COREFIFO: binary write pointer,
// registered Gray export for the CDC path, and full/afull/fill/overflow flags.
module corefifo_wr_ptr_gray_gen
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH    = CF_ADDRWIDTH,
    parameter int AFULL_THRESH = CF_AFULL_THRESH
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH:0]   rd_ptr_gray_s,
    output logic [ADDRWIDTH:0]   wr_ptr_gray,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic                 we,
    output logic                 full,
    output logic                 afull,
    output logic [ADDRWIDTH:0]   wr_cnt,
    output logic                 overflow
);

    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic [PW-1:0] wr_cnt_q, wr_cnt_d;
    logic          overflow_q, overflow_d;

    logic          accept;
    logic [PW-1:0] rbin;
    logic [PW-1:0] fill_nxt;
    logic [PW-1:0] rd_gray_wrapped;

    corefifo_gray2bin #(.W(PW)) u_rd_g2b (
        .gray (rd_ptr_gray_s),
        .bin  (rbin)
    );

    // Full means the write pointer is one lap ahead: in Gray that is the top two
    // bits inverted and the rest equal to the synchronized read pointer.
    assign rd_gray_wrapped = {~rd_ptr_gray_s[PW-1:PW-2], rd_ptr_gray_s[PW-3:0]};

    always_comb begin
        accept        = wr_en & ~full_q;
        wbin_d        = accept ? wbin_q + 1'b1 : wbin_q;
        wr_ptr_gray_d = wbin_d ^ (wbin_d >> 1);
        fill_nxt      = wbin_d - rbin;
        full_d        = (wr_ptr_gray_d == rd_gray_wrapped);
        afull_d       = (fill_nxt >= AFULL_LVL);
        wr_cnt_d      = fill_nxt;
        overflow_d    = wr_en & full_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wbin_q        <= '0;
            wr_ptr_gray_q <= '0;
            full_q        <= 1'b0;
            afull_q       <= 1'b0;
            wr_cnt_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wr_ptr_gray_q <= wr_ptr_gray_d;
            full_q        <= full_d;
            afull_q       <= afull_d;
            wr_cnt_q      <= wr_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_ptr_gray = wr_ptr_gray_q;
    assign waddr       = wbin_q[ADDRWIDTH-1:0];
    assign we          = accept;
    assign full        = full_q;
    assign afull       = afull_q;
    assign wr_cnt      = wr_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_corefifo_wr_ptr_gray_gen.sv
// Bench for the COREFIFO write-side pointer generator (ADDRWIDTH=3, AFULL_THRESH=6).
module tb_corefifo_wr_ptr_gray_gen;

    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 1 << PW;

    logic          clk;
    logic          arst;
    logic          wr_en;
    logic [PW-1:0] rd_ptr_gray_s;
    logic [PW-1:0] wr_ptr_gray;
    logic [AW-1:0] waddr;
    logic          we;
    logic          full;
    logic          afull;
    logic [PW-1:0] wr_cnt;
    logic          overflow;

    corefifo_wr_ptr_gray_gen #(.ADDRWIDTH(AW), .AFULL_THRESH(6)) dut (
        .clk           (clk),
        .arst          (arst),
        .wr_en         (wr_en),
        .rd_ptr_gray_s (rd_ptr_gray_s),
        .wr_ptr_gray   (wr_ptr_gray),
        .waddr         (waddr),
        .we            (we),
        .full          (full),
        .afull         (afull),
        .wr_cnt        (wr_cnt),
        .overflow      (overflow)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    logic [PW-1:0] exp_q[$];

    // reference model: plain integer counts of writes and reader position
    int m_wptr;
    int m_rptr;
    int m_fill;
    bit m_full;
    bit m_ovf;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    function automatic int from_gray(input int g);
        for (int k = 0; k < MOD; k++) begin
            if (to_gray(k) == g) return k;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wptr = 0;
        m_rptr = 0;
        m_fill = 0;
        m_full = 0;
        m_ovf  = 0;
    endtask

    // Drive one cycle. Entered away from the edge; returns 1 time unit after the edge.
    task automatic apply(input bit wen, input int rptr);
        bit            exp_we;
        logic [PW-1:0] prev_gray;
        wr_en         = wen;
        m_rptr        = rptr % MOD;
        rd_ptr_gray_s = PW'(to_gray(m_rptr));
        #1;
        exp_we = wen && !m_full;
        check("we", int'(we), int'(exp_we));
        check("waddr", int'(waddr), m_wptr % DEPTH);
        prev_gray = wr_ptr_gray;
        @(posedge clk);
        m_ovf = wen && m_full;
        if (exp_we) m_wptr = (m_wptr + 1) % MOD;
        m_fill = (m_wptr - m_rptr + MOD) % MOD;
        m_full = (m_fill == DEPTH);
        #1;
        check("full", int'(full), int'(m_full));
        check("afull", int'(afull), int'(m_fill >= 6));
        check("wr_cnt", int'(wr_cnt), m_fill);
        check("wr_ptr_gray", int'(wr_ptr_gray), to_gray(m_wptr));
        check("overflow", int'(overflow), int'(m_ovf));
        check("gray_toggle", $countones(prev_gray ^ wr_ptr_gray), int'(exp_we));
    endtask

    typedef struct {
        logic          wr_en;
        logic [PW-1:0] rd_gray;
        logic          exp_we;
        logic          exp_full;
        logic          exp_afull;
        logic [PW-1:0] exp_cnt;
        logic [PW-1:0] exp_gray;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd1, 4'b0001, 1'b0};
        vecs[2]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd2, 4'b0011, 1'b0};
        vecs[3]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd3, 4'b0010, 1'b0};
        vecs[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd4, 4'b0110, 1'b0};
        vecs[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'd5, 4'b0111, 1'b0};
        vecs[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd6, 4'b0101, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd7, 4'b0100, 1'b0};
        vecs[8]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 4'd8, 4'b1100, 1'b0};
        vecs[9]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd8, 4'b1100, 1'b1};
        vecs[10] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd8, 4'b1100, 1'b1};
        vecs[11] = '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd5, 4'b1100, 1'b0};

        arst          = 1'b1;
        wr_en         = 1'b0;
        rd_ptr_gray_s = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check("rst_full", int'(full), 0);
        check("rst_cnt", int'(wr_cnt), 0);
        check("rst_gray", int'(wr_ptr_gray), 0);
        arst = 1'b0;
        #3;

        // reset release with 5 idle cycles
        for (int i = 0; i < 5; i++) apply(1'b0, 0);

        // fill, overflow, then read pointer drop to bin 3
        for (int i = 0; i < 12; i++) begin
            wr_en         = vecs[i].wr_en;
            rd_ptr_gray_s = vecs[i].rd_gray;
            #1;
            check("vec_we", int'(we), int'(vecs[i].exp_we));
            @(posedge clk);
            #1;
            check("vec_full", int'(full), int'(vecs[i].exp_full));
            check("vec_afull", int'(afull), int'(vecs[i].exp_afull));
            check("vec_cnt", int'(wr_cnt), int'(vecs[i].exp_cnt));
            check("vec_gray", int'(wr_ptr_gray), int'(vecs[i].exp_gray));
            check("vec_ovf", int'(overflow), int'(vecs[i].exp_ovf));
        end
        m_wptr = 8;
        m_rptr = 3;
        m_fill = 5;
        m_full = 0;
        m_ovf  = 0;

        // asynchronous reset between edges at wr_cnt=5
        #2;
        arst = 1'b1;
        #1;
        check("arst_cnt", int'(wr_cnt), 0);
        check("arst_gray", int'(wr_ptr_gray), 0);
        check("arst_full_afull", int'({full, afull, overflow}), 0);
        check("arst_waddr", int'(waddr), 0);
        @(posedge clk);
        #3;
        rd_ptr_gray_s = '0;
        arst = 1'b0;
        model_reset();
        #2;

        // wrap: 16 accepted writes, reader trailing two behind
        for (int k = 1; k <= 2 * DEPTH; k++) exp_q.push_back(PW'(to_gray(k % MOD)));
        for (int k = 0; k < 2 * DEPTH; k++) begin
            logic [PW-1:0] exp_g;
            apply(1'b1, (m_fill >= 2) ? m_rptr + 1 : m_rptr);
            exp_g = exp_q.pop_front();
            check("wrap_scoreboard", int'(wr_ptr_gray), int'(exp_g));
        end
        check("wrap_gray_zero", int'(wr_ptr_gray), 0);

        // randomized traffic with occasional multi-step reader jumps
        for (int n = 0; n < 400; n++) begin
            int  occ;
            int  step;
            bit  wen;
            wen  = ($urandom_range(0, 9) < 7);
            occ  = (m_wptr - m_rptr + MOD) % MOD;
            step = 0;
            if (occ > 0) begin
                if ($urandom_range(0, 7) == 0) step = $urandom_range(1, occ);
                else if ($urandom_range(0, 1) == 1) step = 1;
            end
            apply(wen, m_rptr + step);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
